key_event_ctrl: RTL
===================

KEY_EVENT_CTRL -- requirements
Module: key_event_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 20000, consecutive stable samples required to accept a key change (min 2).
REQ-002 SHALL have parameter CNT_W, default 16, debounce counter width; 2^CNT_W SHALL exceed DEBOUNCE_CYCLES.
REQ-003 clk  input  1  single clock, all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 use_keys  input  8  raw user keys, active-low (0 = pressed), asynchronous to clk.
REQ-006 addr  input  2  word register select (byte address bits [3:2]).
REQ-007 we  input  1  bus write strobe, one cycle per write.
REQ-008 din  input  32  bus write data.
REQ-009 dout  output  32  bus read data, combinational from addr.
REQ-010 irq  output  1  level interrupt request to CPU.

Function
REQ-011 Each key SHALL pass through a two-flop synchronizer, then be inverted so pressed = 1.
REQ-012 Per key: sample != stable state -> counter increments; sample == stable state -> counter clears; counter reaching DEBOUNCE_CYCLES-1 while differing -> stable state takes sample, counter clears.
REQ-013 A clean key change SHALL appear in DATA on the (2 + DEBOUNCE_CYCLES)-th rising clk edge after the use_keys transition.
REQ-014 A glitch shorter than DEBOUNCE_CYCLES samples SHALL NOT change DATA or EVENT.
REQ-015 Register map: addr 0 DATA = {24'h0, stable[7:0]}, read-only; addr 1 EVENT, sticky flags, write-1-to-clear; addr 2 IE = {24'h0, ie[7:0]}, read/write; addr 3 reads 32'h0, writes ignored.
REQ-016 EVENT[7:0] bit k SHALL set on the same edge stable[k] goes 0->1 (press).
REQ-017 New event and W1C clear of the same bit in the same cycle -> bit SHALL end set (set wins).
REQ-018 Writes to DATA SHALL be ignored; IE write takes din[7:0] on that edge; din[31:8] ignored.
REQ-019 irq SHALL equal |(EVENT[7:0] & IE), combinational from registers, no extra latency.
REQ-020 Multiple keys changing simultaneously SHALL be debounced and flagged independently.

Reset
REQ-021 reset low SHALL immediately clear synchronizers to 1 (released), stable states, counters, EVENT, IE; dout = 0 for all addr; irq = 0.
REQ-022 Reset asserted mid-debounce SHALL discard the partial count; after release, counting restarts from zero.
REQ-023 Key held pressed through reset release SHALL produce one press event after 2 + DEBOUNCE_CYCLES cycles.

Configuration
REQ-024 Macro KEY_RELEASE_EVT_EN defined: EVENT[15:8] bit 8+k sets on stable[k] 1->0, same W1C/set-wins rules; IE widens to [15:0]; irq = |(EVENT[15:0] & IE[15:0]).
REQ-025 Macro undefined: EVENT[31:8] and IE[31:8] read 0, release edges generate nothing, no release-path registers exist.

Structure
REQ-026 Shared package key_ctrl_pkg SHALL hold register offsets (ADDR_DATA=0, ADDR_EVENT=1, ADDR_IE=2) and key count constant NUM_KEYS=8.
REQ-027 Per-key synchronizer + debouncer SHALL be sub-module key_debounce (ports: clk, reset, key_n, stable, rise, fall), instantiated 8 times.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 Reset low 3 cycles, release -> DATA=0, EVENT=0, IE=0, irq=0 on all reads.
REQ-029 use_keys[0] 1->0 held; IE=0x01 -> DATA=0x01 and EVENT=0x01 on edge 6, irq=1 same cycle; write EVENT=0x01 -> irq=0 next cycle.
REQ-030 use_keys[3] low 3 cycles then high -> DATA, EVENT unchanged, irq=0.
REQ-031 EVENT=0x04 pending, W1C 0x04 in the cycle key 2 re-press flags -> EVENT reads 0x04.
REQ-032 Reset asserted 2 cycles into debounce of key 5, released with key still low -> DATA[5]=1 on edge 6 after release.
REQ-033 KEY_RELEASE_EVT_EN defined, IE=0x0100, key 0 press then release -> EVENT=0x0101, irq=1 only after release.

Source files
------------

// File: rtl/key_ctrl_pkg.sv
// Shared constants for the key event controller: register offsets, key count and event width.
// EVT_W doubles when KEY_RELEASE_EVT_EN is defined so EVENT/IE also carry release flags.
package key_ctrl_pkg;

    localparam int NUM_KEYS = 8;

    typedef enum logic [1:0] {
        ADDR_DATA  = 2'd0,
        ADDR_EVENT = 2'd1,
        ADDR_IE    = 2'd2,
        ADDR_RSVD  = 2'd3
    } reg_addr_e;

`ifdef KEY_RELEASE_EVT_EN
    localparam int EVT_W = 2 * NUM_KEYS;
`else
    localparam int EVT_W = NUM_KEYS;
`endif

endpackage

// File: rtl/key_event_ctrl_if.sv
// CPU-side register bus of the key event controller: word select, write strobe, data and interrupt.
interface key_event_ctrl_if;

    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    modport master (
        output addr,
        output we,
        output din,
        input  dout,
        input  irq
    );

    modport slave (
        input  addr,
        input  we,
        input  din,
        output dout,
        output irq
    );

endinterface

// File: rtl/key_debounce.sv
// One key: two-flop synchronizer, polarity flip (pressed = 1) and a consecutive-sample debouncer.
// rise/fall are combinational pulses that coincide with the edge on which stable changes.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             sample;
    logic             accept;

    // Synchronizer resets to the released level so a held key is seen as a fresh press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
        end
    end

    assign sample = ~sync2_q;
    assign accept = (sample != stable_q) && (cnt_q == CNT_LAST);

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sample != stable_q) begin
            if (accept) begin
                stable_d = sample;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;
    assign rise   = accept & sample;
    assign fall   = accept & ~sample;

endmodule

// File: rtl/key_event_ctrl.sv
// Eight debounced user keys with sticky W1C press events, interrupt enables and a level irq.
// Define KEY_RELEASE_EVT_EN to add release events in EVENT[15:8] with matching IE[15:8].
module key_event_ctrl
    import key_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int CNT_W           = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] use_keys,
    key_event_ctrl_if.slave     bus
);

    logic [NUM_KEYS-1:0] stable_w;
    logic [NUM_KEYS-1:0] rise_w;
`ifdef KEY_RELEASE_EVT_EN
    logic [NUM_KEYS-1:0] fall_w;
`else
    logic [NUM_KEYS-1:0] fall_unused;
`endif

    logic [EVT_W-1:0] evt_set;
    logic [EVT_W-1:0] event_q;
    logic [EVT_W-1:0] event_d;
    logic [EVT_W-1:0] ie_q;
    logic [EVT_W-1:0] ie_d;
    logic             wr_event;
    logic             wr_ie;
    wire              unused_din_hi = ^bus.din[31:EVT_W];

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_debounce (
            .clk    (clk),
            .reset  (reset),
            .key_n  (use_keys[k]),
            .stable (stable_w[k]),
            .rise   (rise_w[k]),
`ifdef KEY_RELEASE_EVT_EN
            .fall   (fall_w[k])
`else
            .fall   (fall_unused[k])
`endif
        );
    end

`ifdef KEY_RELEASE_EVT_EN
    assign evt_set = {fall_w, rise_w};
`else
    assign evt_set = rise_w;
`endif

    assign wr_event = bus.we && (reg_addr_e'(bus.addr) == ADDR_EVENT);
    assign wr_ie    = bus.we && (reg_addr_e'(bus.addr) == ADDR_IE);

    // Clear is applied before the new events are OR-ed in, so a coincident set wins.
    always_comb begin
        event_d = event_q;
        ie_d    = ie_q;
        if (wr_event) begin
            event_d = event_q & ~bus.din[EVT_W-1:0];
        end
        event_d = event_d | evt_set;
        if (wr_ie) begin
            ie_d = bus.din[EVT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            event_q <= '0;
            ie_q    <= '0;
        end else begin
            event_q <= event_d;
            ie_q    <= ie_d;
        end
    end

    always_comb begin
        bus.dout = '0;
        case (reg_addr_e'(bus.addr))
            ADDR_DATA:  bus.dout = 32'(stable_w);
            ADDR_EVENT: bus.dout = 32'(event_q);
            ADDR_IE:    bus.dout = 32'(ie_q);
            default:    bus.dout = '0;
        endcase
    end

    assign bus.irq = |(event_q & ie_q);

endmodule
